// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared UART definitions: default clock/baud figures and the phase-step
//   calculation used by the baud generator and the UART host-register block.
//   No ports.
package uart_pkg;

  localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;
  localparam int unsigned BAUD_DEFAULT   = 115_200;

  // Rounded phase increment: round(2^acc_w * baud * os / clk_hz).
  // 64-bit intermediate keeps 2^32 * baud * os in range for realistic rates.
  function automatic longint unsigned calc_step(input longint unsigned clk_hz,
                                                input longint unsigned baud,
                                                input longint unsigned os,
                                                input int unsigned     acc_w);
    longint unsigned num;
    num = (64'd1 << acc_w) * baud * os;
    return (num + clk_hz / 2) / clk_hz;
  endfunction

endpackage

// File: rtl/baud_phase_acc.sv
// baud_phase_acc
//   Phase accumulator for the fractional baud generator. Holds the phase and
//   the programmable step, applies rx resync, and reports the add carry.
// Ports:
//   clk_50m    in   system clock
//   rst_n      in   synchronous active-low reset
//   en         in   run enable; accumulator holds while low
//   step_i     in   new phase increment
//   step_wr    in   strobe loading step_i (used by the add on the next cycle)
//   rx_resync  in   strobe clearing the phase
//   carry      out  combinational carry of this cycle's add (0 on resync/idle)
module baud_phase_acc
  import uart_pkg::*;
#(
  parameter int unsigned      ACC_W      = 24,
  parameter logic [ACC_W-1:0] RESET_STEP = '0
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             en,
  input  logic [ACC_W-1:0] step_i,
  input  logic             step_wr,
  input  logic             rx_resync,
  output logic             carry
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] step;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, step};

  // A resync on a carry cycle suppresses the pulse.
  assign carry = en & ~rx_resync & sum[ACC_W];

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      acc  <= '0;
      step <= RESET_STEP;
    end else begin
      if (rx_resync)
        acc <= '0;
      else if (en)
        acc <= sum[ACC_W-1:0];
      // acc is not cleared on a step change so the rate switch is glitch-free.
      if (step_wr)
        step <= step_i;
    end
  end

endmodule

// File: rtl/baud_frac_gen.sv
// baud_frac_gen
//   Fractional baud-rate generator. Emits a one-cycle rx oversample enable on
//   every accumulator carry and a one-cycle tx bit enable on every
//   OVERSAMPLE-th rx enable.
// Ports:
//   clk_50m    in   system clock
//   rst_n      in   synchronous active-low reset
//   en         in   run enable; outputs 0 and state held while low
//   step_i     in   new phase increment
//   step_wr    in   strobe loading step_i
//   rx_resync  in   strobe restarting the rx phase (start-bit detect)
//   rxclk_en   out  registered rx oversample pulse
//   txclk_en   out  registered tx bit pulse, coincident with an rxclk_en pulse
module baud_frac_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = CLK_HZ_DEFAULT,
  parameter int unsigned BAUD       = BAUD_DEFAULT,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned ACC_W      = 24
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             en,
  input  logic [ACC_W-1:0] step_i,
  input  logic             step_wr,
  input  logic             rx_resync,
  output logic             rxclk_en,
  output logic             txclk_en
);

  localparam logic [ACC_W-1:0] DEFAULT_STEP =
    ACC_W'(calc_step(64'(CLK_HZ), 64'(BAUD), 64'(OVERSAMPLE), ACC_W));
  localparam int unsigned      OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);

  if (OVERSAMPLE < 2 || OVERSAMPLE > 64) begin : g_bad_os
    $error("baud_frac_gen: OVERSAMPLE must be 2..64");
  end
  if (ACC_W < 16 || ACC_W > 32) begin : g_bad_accw
    $error("baud_frac_gen: ACC_W must be 16..32");
  end

  logic            carry;
  logic [OS_W-1:0] os_cnt;
  logic            os_wrap;

  baud_phase_acc #(
    .ACC_W      (ACC_W),
    .RESET_STEP (DEFAULT_STEP)
  ) u_phase_acc (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .en        (en),
    .step_i    (step_i),
    .step_wr   (step_wr),
    .rx_resync (rx_resync),
    .carry     (carry)
  );

  assign os_wrap = (os_cnt == OS_LAST);

  // os_cnt only advances on carries, so resync and en=0 leave the tx cadence
  // where it was.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      os_cnt   <= '0;
      rxclk_en <= 1'b0;
      txclk_en <= 1'b0;
    end else begin
      rxclk_en <= carry;
      txclk_en <= carry & os_wrap;
      if (carry)
        os_cnt <= os_wrap ? '0 : os_cnt + OS_W'(1);
    end
  end

endmodule

// File: tb/tb_baud_frac_gen.sv
// tb_baud_frac_gen
//   Scoreboard bench for baud_frac_gen with default parameters. The driver
//   computes the expected pulses from an unbounded phase total (a carry is a
//   crossing of a multiple of 2^ACC_W; tx is every 16th rx pulse since reset)
//   and queues them; a monitor compares them against the DUT outputs.
module tb_baud_frac_gen;

  localparam int     W        = 24;
  localparam longint TWO_W    = 64'd1 << W;
  localparam longint STEP_DEF = 618475;
  localparam longint STEP_2X  = 1236950;
  localparam int     OS       = 16;

  logic         clk_50m = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         step_wr = 1'b0;
  logic         rx_resync = 1'b0;
  logic [W-1:0] step_i = '0;
  logic         rxclk_en;
  logic         txclk_en;

  always #5 clk_50m = ~clk_50m;

  baud_frac_gen dut (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .en        (en),
    .step_i    (step_i),
    .step_wr   (step_wr),
    .rx_resync (rx_resync),
    .rxclk_en  (rxclk_en),
    .txclk_en  (txclk_en)
  );

  typedef struct {
    int unsigned edge_no;
    bit          rx;
    bit          tx;
  } exp_t;

  exp_t        sb[$];
  int unsigned drv_edge = 0;
  int          n_checks = 0;
  int          n_err = 0;

  longint      m_tot = 0;
  longint      m_step = STEP_DEF;
  int unsigned m_pulses = 0;

  int unsigned rx_cnt, tx_cnt, first_rx_edge, last_rx_edge, min_gap, max_gap;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    rx_cnt = 0; tx_cnt = 0; first_rx_edge = 0; last_rx_edge = 0;
    min_gap = 32'hFFFF_FFFF; max_gap = 0;
  endtask

  // Edges until the phase total next crosses a multiple of 2^W.
  function automatic longint cycles_to_carry();
    longint nxt;
    nxt = (m_tot / TWO_W + 1) * TWO_W;
    return (nxt - m_tot + m_step - 1) / m_step;
  endfunction

  // Drive one clock edge and queue the expected outputs after that edge.
  task automatic cyc(input bit e, input bit w, input longint s, input bit rs, input bit rn);
    exp_t it;
    bit   rx;
    en = e; step_wr = w; step_i = W'(s); rx_resync = rs; rst_n = rn;
    rx = 1'b0;
    if (!rn) begin
      m_tot = 0; m_step = STEP_DEF; m_pulses = 0;
    end else begin
      if (rs) m_tot = 0;
      else if (e) begin
        rx = ((m_tot + m_step) / TWO_W) != (m_tot / TWO_W);
        m_tot = m_tot + m_step;
      end
      if (w) m_step = s;
    end
    it.edge_no = drv_edge + 1;
    it.rx = rx;
    it.tx = rx && ((m_pulses % OS) == OS - 1);
    if (rx) m_pulses++;
    sb.push_back(it);
    @(posedge clk_50m);
    drv_edge++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 1);
  endtask

  // Monitor: compares queued expectations against the DUT after each edge.
  initial begin : monitor
    exp_t it;
    int unsigned gap;
    clear_stats();
    forever begin
      @(negedge clk_50m);
      while (sb.size() > 0 && sb[0].edge_no < drv_edge) begin
        it = sb.pop_front();
        n_checks++; n_err++;
        $display("FAIL sb_stale: edge %0d unchecked, now %0d", it.edge_no, drv_edge);
      end
      if (sb.size() > 0 && sb[0].edge_no == drv_edge) begin
        it = sb.pop_front();
        if (it.rx || it.tx || rxclk_en || txclk_en) begin
          n_checks++;
          if (rxclk_en !== it.rx || txclk_en !== it.tx) begin
            n_err++;
            $display("FAIL pulse edge=%0d: got rx=%b tx=%b, expected rx=%b tx=%b",
                     drv_edge, rxclk_en, txclk_en, it.rx, it.tx);
          end
        end
        if (rxclk_en === 1'b1) begin
          rx_cnt++;
          if (first_rx_edge == 0) first_rx_edge = drv_edge;
          if (last_rx_edge != 0) begin
            gap = drv_edge - last_rx_edge;
            if (gap < min_gap) min_gap = gap;
            if (gap > max_gap) max_gap = gap;
          end
          last_rx_edge = drv_edge;
        end
        if (txclk_en === 1'b1) tx_cnt++;
      end
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned r_edge, e_edge, target;
    longint      ideal;
    bit          found;

    // Reset and first tick timing.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    r_edge = drv_edge;
    #3;
    check("reset_rx", rxclk_en, 0);
    check("reset_tx", txclk_en, 0);
    clear_stats();

    // Long run at default rate.
    run(40000);
    check("first_rx_after_reset", first_rx_edge - r_edge, 28);
    ideal = 40000 * STEP_DEF;
    check("rx_rate_window",
          longint'(rx_cnt) * TWO_W <= ideal + TWO_W && longint'(rx_cnt) * TWO_W + TWO_W >= ideal, 1);
    check("tx_count", tx_cnt, rx_cnt / OS);
    check("min_gap_default", min_gap, 27);
    check("max_gap_default", max_gap, 28);

    // Mid-run rate doubling.
    cyc(1, 1, STEP_2X, 0, 1);
    clear_stats();
    run(3000);
    check("min_gap_2x", min_gap, 13);
    check("max_gap_2x", max_gap, 14);

    // Resync exactly on a carry cycle.
    cyc(1, 1, STEP_DEF, 0, 1);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (cycles_to_carry() == 1) found = 1'b1;
      else cyc(1, 0, 0, 0, 1);
    end
    check("resync_carry_found", found, 1);
    cyc(1, 0, 0, 1, 1);
    e_edge = drv_edge;
    #3;
    check("resync_no_pulse", rxclk_en, 0);
    clear_stats();
    run(40);
    check("resync_gap", first_rx_edge - e_edge, (TWO_W + STEP_DEF - 1) / STEP_DEF);

    // Enable pause shifts the next pulse by exactly the pause length.
    run(7);
    target = drv_edge + int'(cycles_to_carry()) + 100;
    clear_stats();
    for (int i = 0; i < 100; i++) cyc(0, 0, 0, 0, 1);
    check("pause_quiet", rx_cnt + tx_cnt, 0);
    run(60);
    check("pause_shift", first_rx_edge, target);

    // Reset after a step change restores the default rate.
    cyc(1, 1, STEP_2X, 0, 1);
    run(100);
    cyc(1, 0, 0, 0, 0);
    r_edge = drv_edge;
    #3;
    check("midreset_rx", rxclk_en, 0);
    check("midreset_tx", txclk_en, 0);
    clear_stats();
    run(600);
    check("midreset_first_rx", first_rx_edge - r_edge, 28);
    check("midreset_max_gap", max_gap, 28);

    // Zero step stops ticking; rewriting the default resumes it.
    cyc(1, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    clear_stats();
    run(10000);
    check("zero_step_quiet", rx_cnt, 0);
    cyc(1, 1, STEP_DEF, 0, 1);
    target = drv_edge + int'(cycles_to_carry());
    clear_stats();
    run(60);
    check("zero_step_resume", first_rx_edge, target);

    // Randomised mix of enables, rate writes, resyncs and resets.
    for (int i = 0; i < 5000; i++) begin
      bit     e, w, rs, rn;
      longint s;
      e  = ($urandom % 8) != 0;
      w  = ($urandom % 50) == 0;
      rs = ($urandom % 40) == 0;
      rn = ($urandom % 997) != 0;
      if ($urandom % 2) s = $urandom_range(100_000, 1_300_000);
      else s = $urandom_range(0, 24'hFF_FFFF);
      cyc(e, w, s, rs, rn);
    end
    run(2);

    @(negedge clk_50m);
    #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/baud_frac_gen.md
# baud_frac_gen

Parametrised fractional baud-rate generator for the UART datapath. It produces a single-cycle receive oversample enable and a single-cycle transmit bit enable from the 50 MHz system clock. A phase accumulator replaces the integer divider, so the long-term rate is exact to within the accumulator resolution. It also adds runtime rate reprogramming, an enable, and a receive phase-resync input driven by the UART receiver on start-bit detection.

## Interface
- CLK_HZ, 50_000_000: input clock frequency.
- BAUD, 115200: default baud rate after reset.
- OVERSAMPLE, 16: rx enables per tx bit; integer, 2 to 64.
- ACC_W, 24: phase accumulator width, 16 to 32.
- DEFAULT_STEP, derived localparam: round(2^ACC_W × BAUD × OVERSAMPLE / CLK_HZ). With the defaults this is 618475.
- clk_50m, input, 1: system clock; all logic on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- en, input, 1: run enable. While low, the accumulator holds and both outputs are 0.
- step_i, input, ACC_W: new phase increment.
- step_wr, input, 1: single-cycle strobe that loads step_i.
- rx_resync, input, 1: single-cycle strobe that restarts rx phase.
- rxclk_en, output, 1: rx oversample enable; one-cycle pulse, registered.
- txclk_en, output, 1: tx bit enable; one-cycle pulse, registered, coincident with an rxclk_en pulse.

## Operation
- State registers:
  - acc[ACC_W-1:0]
  - step[ACC_W-1:0]
  - os_cnt, width $clog2(OVERSAMPLE)
  - rxclk_en and txclk_en output registers
- Reset (rst_n low at the edge): acc = 0, step = DEFAULT_STEP, os_cnt = 0, rxclk_en = 0, txclk_en = 0.
- Each cycle with en = 1 and no rx_resync:
  - {carry, acc} ← acc + step, using ACC_W+1-bit addition with the carry discarded from acc.
  - rxclk_en ← carry.
- Transmit divide, on each cycle where carry = 1:
  - os_cnt ← (os_cnt == OVERSAMPLE-1) ? 0 : os_cnt + 1.
  - txclk_en ← (os_cnt == OVERSAMPLE-1).
  - txclk_en is 0 on all other cycles.
- Rate:
  - Mean rx rate is CLK_HZ × step / 2^ACC_W.
  - Instantaneous rx period is floor or ceil of 2^ACC_W / step, so jitter is at most 1 cycle.
- step_wr:
  - step ← step_i; the new value is used by the add on the following cycle.
  - acc and os_cnt are not cleared, so the rate change is glitch-free.
  - step = 0 is legal and stops all ticks. Any non-zero step is legal; a value of 2^(ACC_W-1) or more gives a carry on every cycle, or on alternate cycles.
- rx_resync:
  - acc ← 0 and rxclk_en ← 0.
  - os_cnt is held and txclk_en ← 0, so the tx bit cadence shifts by one restarted rx period at most.
  - The next rxclk_en follows one full rx period later.
- en = 0:
  - acc, os_cnt and step hold, and outputs are 0.
  - step_wr and rx_resync are still honoured.
- Simultaneous events:
  - rx_resync together with a carry cycle: resync wins and no pulse is emitted.
  - step_wr together with rx_resync: both apply.
  - rst_n low overrides everything.

## Timing
- Output latency: the output is registered on the same edge that updates acc. A carry from the add in cycle N gives a pulse visible during cycle N+1.
- After reset release with defaults, the first rxclk_en appears at cycle ceil(2^24/618475) = 28, counted from the first enabled edge. The first txclk_en appears on the 16th rxclk_en.
- Pulses are exactly one cycle wide. Two rxclk_en pulses are never adjacent unless step ≥ 2^(ACC_W-1).
- Reset mid-operation: outputs are 0 on the cycle after the reset edge, and no partial pulse is emitted.

## Structure
- The shared package uart_pkg holds:
  - the CLK_HZ and BAUD defaults
  - a function calc_step(clk_hz, baud, os, acc_w) returning the rounded increment, also used by the UART host-register block
- One sub-module, baud_phase_acc, contains the accumulator, step register and resync, and outputs the carry. The top level adds the OVERSAMPLE counter and the output registers.

## Test plan
- Defaults, en = 1, run 1,000,000 cycles:
  - expect 36864 ±1 rxclk_en pulses and 2304 ±1 txclk_en pulses
  - every rx interval is 27 or 28 cycles
- step_wr with step_i = 1236950 mid-run (230400 baud):
  - the next interval is already 13 or 14 cycles
  - os_cnt continuity is preserved, and there is no double pulse
- rx_resync asserted on the same cycle as an expected carry:
  - no pulse that cycle
  - the next rxclk_en arrives 27–28 cycles later
  - the txclk_en phase is delayed accordingly
- en low for 100 cycles then high:
  - no pulses while low
  - the next pulse lands exactly 100 cycles later than it would have without the pause
- rst_n low for 1 cycle mid-run after a step change:
  - outputs are 0 on the next cycle
  - the rate returns to DEFAULT_STEP with first rxclk_en at cycle 28
- step_i = 0 via step_wr:
  - no pulses for 10,000 cycles
  - rewriting 618475 resumes ticking without reset
